// File: rtl/exe_sched_pkg.sv
// Shared types and defaults for the execute-slot issue scheduler.
package exe_sched_pkg;

    // Scheduler occupancy state: slot free, or held by a multi-cycle MULT/DIV
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } sched_state_e;

    // EXE operand mux select encoding
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_LS  = 1'b1;

    // Default tuning values
    localparam int DEF_STARVE_LIMIT = 32'd4;
    localparam int DEF_MD_LATENCY   = 32'd4;

endpackage

// File: rtl/rob_age_cmp.sv
// Combinational ROB age comparator: is pointer a older than pointer b
// relative to the current ROB head. Wrap is absorbed by modulo subtraction.
module rob_age_cmp #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] head,
    output logic         a_older
);

    logic [W-1:0] age_a_s;
    logic [W-1:0] age_b_s;

    // Distance from head, truncated to W bits, is each pointer's age
    always_comb begin
        age_a_s = a - head;
        age_b_s = b - head;
        a_older = (age_a_s < age_b_s);
    end

endmodule

// File: rtl/exe_issue_arbiter.sv
// Execute-slot issue arbiter: picks ALU queue or LSQ each cycle, oldest
// first with a starvation override, and holds the slot for MULT/DIV.
module exe_issue_arbiter
    import exe_sched_pkg::*;
#(
    parameter int ROBWIDTH     = 6,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int MD_LATENCY   = DEF_MD_LATENCY
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FREEZE,
    input  logic                FLUSH,
    input  logic [ROBWIDTH-1:0] ROB_HEAD,
    input  logic                ALU_VALID,
    input  logic [ROBWIDTH-1:0] ALU_ROB,
    input  logic                ALU_MULDIV,
    output logic                ALU_READY,
    input  logic                LS_VALID,
    input  logic [ROBWIDTH-1:0] LS_ROB,
    output logic                LS_READY,
    output logic                ISSUE_VALID,
    output logic                ISSUE_SEL,
    output logic [ROBWIDTH-1:0] ISSUE_ROB,
    output logic                EXE_BUSY
);

    localparam int LW = $clog2(STARVE_LIMIT + 1);
    localparam int MW = $clog2(MD_LATENCY);
    localparam logic [LW-1:0] LIMIT_C   = LW'(STARVE_LIMIT);
    localparam logic [MW-1:0] MD_LOAD_C = MW'(MD_LATENCY - 1);

    sched_state_e        state_r;
    sched_state_e        state_nxt_s;
    logic [MW-1:0]       md_cnt_r;
    logic [MW-1:0]       md_cnt_nxt_s;
    logic [LW-1:0]       alu_loss_r;
    logic [LW-1:0]       alu_loss_nxt_s;
    logic [LW-1:0]       ls_loss_r;
    logic [LW-1:0]       ls_loss_nxt_s;
    logic                slot_free_s;
    logic                alu_older_s;
    logic                alu_grant_s;
    logic                ls_grant_s;
    logic                issue_valid_r;
    logic                issue_sel_r;
    logic [ROBWIDTH-1:0] issue_rob_r;
    logic                exe_busy_r;

    // Loss counter update: clear on win or absence, saturating count on loss
    function automatic logic [LW-1:0] loss_next(input logic [LW-1:0] cur,
                                                input logic          valid,
                                                input logic          won,
                                                input logic          lost);
        logic [LW-1:0] res;
        if (won || !valid) begin
            res = {LW{1'b0}};
        end else if (lost) begin
            res = (cur == LIMIT_C) ? cur : cur + LW'(1);
        end else begin
            res = cur;
        end
        return res;
    endfunction

    rob_age_cmp #(
        .W(ROBWIDTH)
    ) u_age_cmp (
        .a       (ALU_ROB),
        .b       (LS_ROB),
        .head    (ROB_HEAD),
        .a_older (alu_older_s)
    );

    // Grant selection: starved requester first (LS on a double tie), else oldest
    always_comb begin
        alu_grant_s = 1'b0;
        ls_grant_s  = 1'b0;
        // The last MULT/DIV cycle already frees the slot for the next issue
        slot_free_s = (state_r == IDLE) || (md_cnt_r == MW'(1));
        if (RESET && !FREEZE && !FLUSH && slot_free_s) begin
            if (ALU_VALID && LS_VALID) begin
                if (ls_loss_r == LIMIT_C) begin
                    ls_grant_s = 1'b1;
                end else if (alu_loss_r == LIMIT_C) begin
                    alu_grant_s = 1'b1;
                end else if (alu_older_s) begin
                    alu_grant_s = 1'b1;
                end else begin
                    ls_grant_s = 1'b1;
                end
            end else begin
                alu_grant_s = ALU_VALID;
                ls_grant_s  = LS_VALID;
            end
        end else begin
            alu_grant_s = 1'b0;
            ls_grant_s  = 1'b0;
        end
    end

    assign ALU_READY = alu_grant_s;
    assign LS_READY  = ls_grant_s;

    // Next state, MULT/DIV occupancy counter and loss counters
    always_comb begin
        state_nxt_s    = state_r;
        md_cnt_nxt_s   = md_cnt_r;
        alu_loss_nxt_s = alu_loss_r;
        ls_loss_nxt_s  = ls_loss_r;
        if (FLUSH) begin
            state_nxt_s    = IDLE;
            md_cnt_nxt_s   = {MW{1'b0}};
            alu_loss_nxt_s = {LW{1'b0}};
            ls_loss_nxt_s  = {LW{1'b0}};
        end else if (FREEZE) begin
            state_nxt_s    = state_r;
            md_cnt_nxt_s   = md_cnt_r;
        end else begin
            alu_loss_nxt_s = loss_next(alu_loss_r, ALU_VALID, alu_grant_s, ls_grant_s);
            ls_loss_nxt_s  = loss_next(ls_loss_r, LS_VALID, ls_grant_s, alu_grant_s);
            case (state_r)
                IDLE: begin
                    if (alu_grant_s && ALU_MULDIV) begin
                        state_nxt_s  = MD_BUSY;
                        md_cnt_nxt_s = MD_LOAD_C;
                    end else begin
                        state_nxt_s  = IDLE;
                        md_cnt_nxt_s = {MW{1'b0}};
                    end
                end
                MD_BUSY: begin
                    if (alu_grant_s && ALU_MULDIV) begin
                        state_nxt_s  = MD_BUSY;
                        md_cnt_nxt_s = MD_LOAD_C;
                    end else if (md_cnt_r <= MW'(1)) begin
                        state_nxt_s  = IDLE;
                        md_cnt_nxt_s = {MW{1'b0}};
                    end else begin
                        state_nxt_s  = MD_BUSY;
                        md_cnt_nxt_s = md_cnt_r - MW'(1);
                    end
                end
                default: begin
                    state_nxt_s  = IDLE;
                    md_cnt_nxt_s = {MW{1'b0}};
                end
            endcase
        end
    end

    // State, counters and issue registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r       <= IDLE;
            md_cnt_r      <= {MW{1'b0}};
            alu_loss_r    <= {LW{1'b0}};
            ls_loss_r     <= {LW{1'b0}};
            issue_valid_r <= 1'b0;
            issue_sel_r   <= 1'b0;
            issue_rob_r   <= {ROBWIDTH{1'b0}};
            exe_busy_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            md_cnt_r   <= md_cnt_nxt_s;
            alu_loss_r <= alu_loss_nxt_s;
            ls_loss_r  <= ls_loss_nxt_s;
            exe_busy_r <= (state_nxt_s == MD_BUSY);
            if (FLUSH) begin
                // Select and pointer stay so EXE's operand mux does not glitch
                issue_valid_r <= 1'b0;
            end else if (FREEZE) begin
                issue_valid_r <= issue_valid_r;
            end else begin
                issue_valid_r <= alu_grant_s | ls_grant_s;
                if (ls_grant_s) begin
                    issue_sel_r <= SEL_LS;
                    issue_rob_r <= LS_ROB;
                end else if (alu_grant_s) begin
                    issue_sel_r <= SEL_ALU;
                    issue_rob_r <= ALU_ROB;
                end else begin
                    issue_sel_r <= issue_sel_r;
                    issue_rob_r <= issue_rob_r;
                end
            end
        end
    end

    assign ISSUE_VALID = issue_valid_r;
    assign ISSUE_SEL   = issue_sel_r;
    assign ISSUE_ROB   = issue_rob_r;
    assign EXE_BUSY    = exe_busy_r;

endmodule

// File: tb/tb_exe_issue_arbiter.sv
// Self-checking bench for exe_issue_arbiter: directed scenarios plus a
// randomized run, all compared against a cycle-counting behavioural model.
module tb_exe_issue_arbiter;

    localparam int ROBW   = 6;
    localparam int STARVE = 4;
    localparam int MDL    = 4;
    localparam int ROBN   = 1 << ROBW;

    logic            CLK, RESET, FREEZE, FLUSH;
    logic [ROBW-1:0] ROB_HEAD, ALU_ROB, LS_ROB, ISSUE_ROB;
    logic            ALU_VALID, ALU_MULDIV, ALU_READY, LS_VALID, LS_READY;
    logic            ISSUE_VALID, ISSUE_SEL, EXE_BUSY;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int              m_alu_loss, m_ls_loss, m_elapsed;
    bit              m_md_live, m_iv, m_sel;
    logic [ROBW-1:0] m_rob;
    bit              e_alu, e_ls;
    // Inputs of the cycle in flight
    bit              c_rst, c_frz, c_fl, c_av, c_amd, c_lv;
    int              c_arob, c_lrob;

    logic [ROBW+4:0] got_v, exp_v;
    logic [3:0]      got4;
    logic [3:0]      md_exp [0:4];
    logic [9:0]      ls_pat10;
    logic [8:0]      alu_pat9, ls_pat9;

    exe_issue_arbiter #(
        .ROBWIDTH(ROBW), .STARVE_LIMIT(STARVE), .MD_LATENCY(MDL)
    ) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH),
        .ROB_HEAD(ROB_HEAD),
        .ALU_VALID(ALU_VALID), .ALU_ROB(ALU_ROB), .ALU_MULDIV(ALU_MULDIV),
        .ALU_READY(ALU_READY),
        .LS_VALID(LS_VALID), .LS_ROB(LS_ROB), .LS_READY(LS_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_SEL(ISSUE_SEL), .ISSUE_ROB(ISSUE_ROB),
        .EXE_BUSY(EXE_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int age_of(int x, int h);
        return (((x - h) % ROBN) + ROBN) % ROBN;
    endfunction

    function automatic logic [ROBW+4:0] dut_vec();
        return {ALU_READY, LS_READY, ISSUE_VALID, ISSUE_SEL, ISSUE_ROB, EXE_BUSY};
    endfunction

    function automatic logic [ROBW+4:0] model_vec();
        return {e_alu, e_ls, m_iv, m_sel, m_rob, m_md_live};
    endfunction

    // Drive one cycle's inputs, move to the falling edge, predict the grants
    task automatic apply(input bit rst, input bit frz, input bit fl, input bit av,
                         input bit amd, input bit lv, input int arob,
                         input int lrob, input int head);
        RESET = rst; FREEZE = frz; FLUSH = fl;
        ALU_VALID = av; ALU_MULDIV = amd; LS_VALID = lv;
        ALU_ROB = arob[ROBW-1:0]; LS_ROB = lrob[ROBW-1:0]; ROB_HEAD = head[ROBW-1:0];
        c_rst = rst; c_frz = frz; c_fl = fl; c_av = av; c_amd = amd; c_lv = lv;
        c_arob = arob; c_lrob = lrob;
        @(negedge CLK);
        e_alu = 1'b0;
        e_ls  = 1'b0;
        if (rst && !frz && !fl && (!m_md_live || m_elapsed >= MDL - 1)) begin
            if (av && lv) begin
                if (m_ls_loss == STARVE) e_ls = 1'b1;
                else if (m_alu_loss == STARVE) e_alu = 1'b1;
                else if (age_of(arob, head) < age_of(lrob, head)) e_alu = 1'b1;
                else e_ls = 1'b1;
            end else begin
                e_alu = av;
                e_ls  = lv;
            end
        end
    endtask

    // Clock edge: advance the model by the rules of one cycle
    task automatic advance();
        @(posedge CLK);
        if (!c_rst) begin
            m_alu_loss = 0; m_ls_loss = 0; m_elapsed = 0; m_md_live = 0;
            m_iv = 0; m_sel = 0; m_rob = '0;
        end else if (c_fl) begin
            m_iv = 0; m_md_live = 0; m_elapsed = 0; m_alu_loss = 0; m_ls_loss = 0;
        end else if (!c_frz) begin
            m_iv = e_alu | e_ls;
            if (e_alu) begin m_sel = 0; m_rob = c_arob[ROBW-1:0]; end
            else if (e_ls) begin m_sel = 1; m_rob = c_lrob[ROBW-1:0]; end
            if (e_alu || !c_av) m_alu_loss = 0;
            else if (e_ls && m_alu_loss < STARVE) m_alu_loss++;
            if (e_ls || !c_lv) m_ls_loss = 0;
            else if (e_alu && m_ls_loss < STARVE) m_ls_loss++;
            if (e_alu && c_amd) begin
                m_md_live = 1; m_elapsed = 1;
            end else if (m_md_live) begin
                m_elapsed++;
                if (m_elapsed >= MDL) m_md_live = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 1, 0, 1, 5, 9, 0);
        checks++;
        if ({ALU_READY, LS_READY} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b exp=00", {ALU_READY, LS_READY});
        end
        advance();
        apply(0, 0, 0, 1, 1, 1, 5, 9, 0);
        checks++;
        if ({ISSUE_VALID, ISSUE_SEL, ISSUE_ROB, EXE_BUSY} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", {ISSUE_VALID, ISSUE_SEL, ISSUE_ROB, EXE_BUSY});
        end
        got_v = dut_vec(); exp_v = model_vec(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL reset_model got=%h exp=%h", got_v, exp_v); end
        advance();
        idle(2);
    endtask

    task automatic test_wrap();
        apply(1, 0, 0, 1, 0, 1, 2, 62, 60);
        checks++;
        if ({ALU_READY, LS_READY} !== 2'b01) begin
            errors++; $display("FAIL wrap_ready got=%b exp=01", {ALU_READY, LS_READY});
        end
        advance();
        apply(1, 0, 0, 0, 0, 0, 2, 62, 60);
        checks++;
        if ({ISSUE_VALID, ISSUE_SEL, ISSUE_ROB} !== {1'b1, 1'b1, 6'd62}) begin
            errors++; $display("FAIL wrap_issue got=%h exp=%h", {ISSUE_VALID, ISSUE_SEL, ISSUE_ROB}, {1'b1, 1'b1, 6'd62});
        end
        got_v = dut_vec(); exp_v = model_vec(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL wrap_model got=%h exp=%h", got_v, exp_v); end
        advance();
    endtask

    task automatic test_starvation();
        idle(1);
        ls_pat10 = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 0, 1, 0, 1, 3, 10, 0);
            checks++;
            if ({ALU_READY, LS_READY} !== {~ls_pat10[i], ls_pat10[i]}) begin
                errors++; $display("FAIL starve_grant cyc=%0d got=%b exp=%b", i, {ALU_READY, LS_READY}, {~ls_pat10[i], ls_pat10[i]});
            end
            got_v = dut_vec(); exp_v = model_vec(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL starve_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
            advance();
        end
        idle(1);
    endtask

    task automatic test_muldiv();
        md_exp = '{4'b1000, 4'b0011, 4'b0001, 4'b0101, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, (i == 0), 1, (i >= 1 && i <= 3), 20, 25, 16);
            got4 = {ALU_READY, LS_READY, ISSUE_VALID, EXE_BUSY}; checks++;
            if (got4 !== md_exp[i]) begin
                errors++; $display("FAIL muldiv_timing cyc=%0d got=%b exp=%b", i, got4, md_exp[i]);
            end
            got_v = dut_vec(); exp_v = model_vec(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL muldiv_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
            advance();
        end
        checks++;
        if ({ISSUE_SEL, ISSUE_ROB} !== {1'b1, 6'd25}) begin
            errors++; $display("FAIL muldiv_ls_issue got=%h exp=%h", {ISSUE_SEL, ISSUE_ROB}, {1'b1, 6'd25});
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 1, 0, 0, 10 + i, 50, 0);
            checks++;
            if (ALU_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, ALU_READY); end
            if (i > 0) begin
                checks++;
                if ({ISSUE_VALID, ISSUE_ROB} !== {1'b1, 6'(10 + i - 1)}) begin
                    errors++; $display("FAIL b2b_issue cyc=%0d got=%h exp=%h", i, {ISSUE_VALID, ISSUE_ROB}, {1'b1, 6'(10 + i - 1)});
                end
            end
            advance();
        end
        idle(1);
    endtask

    task automatic test_freeze();
        alu_pat9 = 9'b1_0100_0111;
        ls_pat9  = 9'b0_1000_0000;
        for (int i = 0; i < 9; i++) begin
            apply(1, (i >= 3 && i <= 5), 0, 1, 0, 1, 5, 40, 0);
            checks++;
            if ({ALU_READY, LS_READY} !== {alu_pat9[i], ls_pat9[i]}) begin
                errors++; $display("FAIL freeze_grant cyc=%0d got=%b exp=%b", i, {ALU_READY, LS_READY}, {alu_pat9[i], ls_pat9[i]});
            end
            if (i >= 3 && i <= 6) begin
                checks++;
                if ({ISSUE_VALID, ISSUE_SEL, ISSUE_ROB} !== {1'b1, 1'b0, 6'd5}) begin
                    errors++; $display("FAIL freeze_hold cyc=%0d got=%h exp=%h", i, {ISSUE_VALID, ISSUE_SEL, ISSUE_ROB}, {1'b1, 1'b0, 6'd5});
                end
            end
            got_v = dut_vec(); exp_v = model_vec(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL freeze_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
            advance();
        end
        idle(1);
    endtask

    task automatic test_flush();
        apply(1, 0, 0, 1, 1, 0, 30, 31, 0);
        checks++;
        if (ALU_READY !== 1'b1) begin errors++; $display("FAIL flush_md_accept got=%b exp=1", ALU_READY); end
        advance();
        apply(1, 0, 1, 0, 0, 1, 30, 31, 0);
        checks++;
        if ({ALU_READY, LS_READY, EXE_BUSY} !== 3'b001) begin
            errors++; $display("FAIL flush_busy_ready got=%b exp=001", {ALU_READY, LS_READY, EXE_BUSY});
        end
        advance();
        apply(1, 0, 0, 0, 0, 1, 30, 31, 0);
        checks++;
        if ({ISSUE_VALID, EXE_BUSY, ISSUE_SEL, ISSUE_ROB, LS_READY} !== {1'b0, 1'b0, 1'b0, 6'd30, 1'b1}) begin
            errors++; $display("FAIL flush_after_md got=%h exp=%h", {ISSUE_VALID, EXE_BUSY, ISSUE_SEL, ISSUE_ROB, LS_READY}, {1'b0, 1'b0, 1'b0, 6'd30, 1'b1});
        end
        advance();
        apply(1, 1, 1, 1, 0, 0, 30, 31, 0);
        checks++;
        if ({ALU_READY, LS_READY, ISSUE_VALID} !== 3'b001) begin
            errors++; $display("FAIL flush_freeze_ready got=%b exp=001", {ALU_READY, LS_READY, ISSUE_VALID});
        end
        advance();
        apply(1, 0, 0, 0, 0, 0, 30, 31, 0);
        checks++;
        if ({ISSUE_VALID, EXE_BUSY, ISSUE_SEL, ISSUE_ROB} !== {1'b0, 1'b0, 1'b1, 6'd31}) begin
            errors++; $display("FAIL flush_freeze_after got=%h exp=%h", {ISSUE_VALID, EXE_BUSY, ISSUE_SEL, ISSUE_ROB}, {1'b0, 1'b0, 1'b1, 6'd31});
        end
        got_v = dut_vec(); exp_v = model_vec(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL flush_model got=%h exp=%h", got_v, exp_v); end
        advance();
    endtask

    task automatic test_reset_during_md();
        apply(1, 0, 0, 1, 1, 0, 7, 8, 0);
        checks++;
        if (ALU_READY !== 1'b1) begin errors++; $display("FAIL rstmd_accept got=%b exp=1", ALU_READY); end
        advance();
        apply(0, 0, 0, 0, 0, 1, 7, 8, 0);
        checks++;
        if ({ALU_READY, LS_READY, EXE_BUSY} !== 3'b001) begin
            errors++; $display("FAIL rstmd_low got=%b exp=001", {ALU_READY, LS_READY, EXE_BUSY});
        end
        advance();
        apply(1, 0, 0, 0, 0, 1, 7, 8, 0);
        checks++;
        if ({ISSUE_VALID, ISSUE_SEL, ISSUE_ROB, EXE_BUSY, LS_READY} !== {9'd0, 1'b1}) begin
            errors++; $display("FAIL rstmd_cleared got=%h exp=%h", {ISSUE_VALID, ISSUE_SEL, ISSUE_ROB, EXE_BUSY, LS_READY}, {9'd0, 1'b1});
        end
        advance();
        apply(1, 0, 0, 0, 0, 0, 7, 8, 0);
        checks++;
        if ({ISSUE_VALID, ISSUE_SEL, ISSUE_ROB} !== {1'b1, 1'b1, 6'd8}) begin
            errors++; $display("FAIL rstmd_first_issue got=%h exp=%h", {ISSUE_VALID, ISSUE_SEL, ISSUE_ROB}, {1'b1, 1'b1, 6'd8});
        end
        advance();
    endtask

    task automatic test_random();
        int arob, lrob;
        for (int i = 0; i < 600; i++) begin
            arob = int'($urandom_range(0, ROBN - 1));
            lrob = (arob + 1 + int'($urandom_range(0, ROBN - 2))) % ROBN;
            apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  arob, lrob, int'($urandom_range(0, ROBN - 1)));
            got_v = dut_vec(); exp_v = model_vec(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
            advance();
        end
    endtask

    initial begin
        m_alu_loss = 0; m_ls_loss = 0; m_elapsed = 0; m_md_live = 0;
        m_iv = 0; m_sel = 0; m_rob = '0; e_alu = 0; e_ls = 0;
        RESET = 1'b0; FREEZE = 1'b0; FLUSH = 1'b0;
        ALU_VALID = 1'b0; ALU_MULDIV = 1'b0; LS_VALID = 1'b0;
        ALU_ROB = '0; LS_ROB = '0; ROB_HEAD = '0;
        test_reset();
        test_wrap();
        test_starvation();
        test_muldiv();
        test_back_to_back();
        test_freeze();
        test_flush();
        test_reset_during_md();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
